// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receiver, transmitter and command framer.
package uart_pkg;

    // Start bit + 8 data bits + stop bit.
    localparam int BITS_PER_FRAME = 10;

    typedef enum logic {WAIT_HI, WAIT_LO} framer_state_t;

endpackage

// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer: pairs received UART bytes into 16-bit commands, with an inter-byte timeout and overrun flag.
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous reset, active low
//   rx_data      in   [7:0] byte from receiver, valid while rx_rdy high
//   rx_rdy       in   receiver byte-ready, pulse or held level
//   clr_rx_rdy   out  1-cycle acknowledge of a consumed byte
//   cmd          out  [15:0] assembled command {high_byte, low_byte}
//   cmd_rdy      out  command valid, held until clr_cmd_rdy
//   clr_cmd_rdy  in   consumer acknowledge, clears cmd_rdy and overrun
//   overrun      out  sticky: a command completed while cmd_rdy was still high
//   timeout      out  1-cycle pulse: high byte dropped, low byte never arrived
module uart_cmd_framer
    import uart_pkg::*;
#(
    parameter int CLK_RATE     = 50_000_000,
    parameter int BAUD_RATE    = 19200,
    parameter int GAP_BYTES    = 4,
    parameter int TIMEOUT_CLKS = (CLK_RATE / BAUD_RATE) * BITS_PER_FRAME * GAP_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        overrun,
    output logic        timeout
);

    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);

    framer_state_t state, state_next;
    logic [TW-1:0] timer;
    logic [7:0]    hi_reg;
    logic          rx_rdy_q;
    logic          accept;
    logic          load_hi;
    logic          done;

    // Rising-edge detect so a receiver that holds rx_rdy high yields one byte.
    assign accept = rx_rdy & ~rx_rdy_q;

    always_comb begin
        state_next = state;
        load_hi    = 1'b0;
        done       = 1'b0;
        timeout    = 1'b0;
        case (state)
            WAIT_HI: begin
                load_hi    = accept;
                state_next = accept ? WAIT_LO : WAIT_HI;
            end
            WAIT_LO: begin
                // A byte arriving on the terminal count still completes the command.
                done       = accept;
                timeout    = ~accept & (timer == T_LAST);
                state_next = (done | timeout) ? WAIT_HI : WAIT_LO;
            end
            default: state_next = WAIT_HI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_HI;
            timer      <= '0;
            hi_reg     <= '0;
            rx_rdy_q   <= 1'b0;
            clr_rx_rdy <= 1'b0;
            cmd        <= '0;
            cmd_rdy    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_next;
            rx_rdy_q   <= rx_rdy;
            clr_rx_rdy <= accept;
            // Leaving WAIT_LO always resets the timer, so it can never wrap.
            timer      <= (state == WAIT_LO && state_next == WAIT_LO) ? timer + 1'b1 : '0;
            if (load_hi)
                hi_reg <= rx_data;
            else if (timeout)
                hi_reg <= '0;
            if (done)
                cmd <= {hi_reg, rx_data};
            // A completion beats a simultaneous acknowledge and is not an overrun.
            cmd_rdy <= done | (cmd_rdy & ~clr_cmd_rdy);
            overrun <= ~clr_cmd_rdy & (overrun | (done & cmd_rdy));
        end
    end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// tb_uart_cmd_framer: self-checking bench for uart_cmd_framer using a timestamp-based reference model.
module tb_uart_cmd_framer;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_rdy = 1'b0;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        overrun;
    logic        timeout;

    uart_cmd_framer #(.TIMEOUT_CLKS(TO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_rdy(rx_rdy),
        .clr_rx_rdy(clr_rx_rdy),
        .cmd(cmd),
        .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .overrun(overrun),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: a pending high byte is remembered with the cycle it arrived in;
    // a low byte is accepted up to TO cycles later, otherwise it is dropped at exactly TO.
    int          cyc = 0;
    logic        m_prev = 1'b0;
    logic        m_have = 1'b0;
    logic [7:0]  m_hi = '0;
    int          m_hcyc = 0;
    logic        m_clr = 1'b0;
    logic [15:0] m_cmd = '0;
    logic        m_rdy = 1'b0;
    logic        m_ovr = 1'b0;

    int to_cnt = 0;
    int to_cyc = -1;
    int clr_cnt = 0;

    typedef struct {
        logic [7:0]  data;
        logic        clr;
        logic [15:0] exp_cmd;
        logic        exp_rdy;
        logic        exp_ovr;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = 1'b0;
        m_have = 1'b0;
        m_clr  = 1'b0;
        m_cmd  = '0;
        m_rdy  = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare every output with the model, advance the model.
    task automatic step(input logic r, input logic [7:0] d, input logic c);
        logic acc;
        logic exp_to;
        rx_rdy = r;
        rx_data = d;
        clr_cmd_rdy = c;
        #1;
        acc = r & ~m_prev;
        exp_to = m_have && !acc && (cyc - m_hcyc == TO);
        check("cycle", {43'd0, clr_rx_rdy, cmd, cmd_rdy, overrun, timeout},
                       {43'd0, m_clr, m_cmd, m_rdy, m_ovr, exp_to});
        if (timeout) begin
            to_cnt++;
            to_cyc = cyc;
        end
        if (clr_rx_rdy)
            clr_cnt++;
        m_clr = acc;
        if (acc && m_have) begin
            m_ovr  = ~c & (m_ovr | m_rdy);
            m_cmd  = {m_hi, d};
            m_rdy  = 1'b1;
            m_have = 1'b0;
        end else begin
            if (c) begin
                m_rdy = 1'b0;
                m_ovr = 1'b0;
            end
            if (acc) begin
                m_have = 1'b1;
                m_hi   = d;
                m_hcyc = cyc;
            end else if (exp_to) begin
                m_have = 1'b0;
            end
        end
        m_prev = r;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, $urandom_range(255), 1'b0);
    endtask

    initial begin
        int c0, t0, hc;
        tbl[0] = '{8'hA5, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b0, 16'hA53C, 1'b1, 1'b0};
        tbl[2] = '{8'h11, 1'b1, 16'hA53C, 1'b0, 1'b0};
        tbl[3] = '{8'h11, 1'b0, 16'h1111, 1'b1, 1'b0};
        tbl[4] = '{8'h22, 1'b0, 16'h1111, 1'b1, 1'b0};
        tbl[5] = '{8'h22, 1'b0, 16'h2222, 1'b1, 1'b1};
        tbl[6] = '{8'h77, 1'b1, 16'h2222, 1'b0, 1'b0};
        tbl[7] = '{8'h88, 1'b0, 16'h7788, 1'b1, 1'b0};
        tbl[8] = '{8'h99, 1'b0, 16'h7788, 1'b1, 1'b0};
        tbl[9] = '{8'h9A, 1'b1, 16'h999A, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {42'd0, clr_rx_rdy, cmd, cmd_rdy, overrun, timeout}, 64'd0);
        rst_n = 1'b1;
        model_reset();

        // Basic assembly, overrun, acknowledge and collision, 20 idle cycles apart.
        c0 = clr_cnt;
        for (int i = 0; i < 10; i++) begin
            idle(20);
            step(1'b1, tbl[i].data, tbl[i].clr);
            check($sformatf("table_%0d", i), {44'd0, cmd, cmd_rdy, overrun, clr_rx_rdy, timeout},
                  {44'd0, tbl[i].exp_cmd, tbl[i].exp_rdy, tbl[i].exp_ovr, 1'b1, 1'b0});
            if (i == 1) begin
                idle(1);
                check("basic_clr_rx_pulses", clr_cnt - c0, 2);
            end
        end
        idle(3);
        step(1'b0, 8'h00, 1'b1);

        // Held level counts as one byte.
        c0 = clr_cnt;
        for (int i = 0; i < 50; i++)
            step(1'b1, 8'h12, 1'b0);
        idle(5);
        check("held_single_accept", clr_cnt - c0, 1);
        step(1'b1, 8'h34, 1'b0);
        idle(2);
        check("held_clr_rx_pulses", clr_cnt - c0, 2);
        check("held_cmd", cmd, 16'h1234);
        step(1'b0, 8'h00, 1'b1);

        // Timeout resync: lone 0xFF is dropped exactly TO cycles after its accept.
        t0 = to_cnt;
        hc = cyc;
        step(1'b1, 8'hFF, 1'b0);
        idle(TO + 5);
        check("timeout_count", to_cnt - t0, 1);
        check("timeout_cycle", to_cyc, hc + TO);
        step(1'b1, 8'h01, 1'b0);
        idle(3);
        step(1'b1, 8'h02, 1'b0);
        idle(1);
        check("resync_cmd", cmd, 16'h0102);
        check("resync_timeout_count", to_cnt - t0, 1);
        step(1'b0, 8'h00, 1'b1);

        // Timeout tie: low byte lands on the terminal count and wins.
        t0 = to_cnt;
        step(1'b1, 8'h5A, 1'b0);
        idle(TO - 1);
        step(1'b1, 8'hC3, 1'b0);
        idle(TO + 5);
        check("tie_no_timeout", to_cnt - t0, 0);
        check("tie_cmd", {cmd, cmd_rdy, overrun}, {16'h5AC3, 1'b1, 1'b0});

        // Reset mid-command drops the partial byte.
        step(1'b1, 8'h55, 1'b0);
        idle(3);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {42'd0, clr_rx_rdy, cmd, cmd_rdy, overrun, timeout}, 64'd0);
        @(posedge clk);
        #1;
        check("held_reset_outputs", {42'd0, clr_rx_rdy, cmd, cmd_rdy, overrun, timeout}, 64'd0);
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 8'hAB, 1'b0);
        idle(4);
        step(1'b1, 8'hCD, 1'b0);
        idle(1);
        check("post_reset_cmd", {cmd, cmd_rdy, overrun}, {16'hABCD, 1'b1, 1'b0});

        // Random traffic: short gaps, near-timeout gaps, held levels, random acknowledges.
        for (int i = 0; i < 150; i++) begin
            int gap, len;
            logic [7:0] d;
            gap = ($urandom_range(3) == 0) ? TO - 5 + $urandom_range(10) : $urandom_range(6);
            for (int g = 0; g < gap; g++)
                step(1'b0, $urandom_range(255), ($urandom_range(7) == 0));
            len = 1 + $urandom_range(2);
            d = $urandom_range(255);
            for (int l = 0; l < len; l++)
                step(1'b1, d, ($urandom_range(4) == 0));
        end
        idle(TO + 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_framer.md
Name: uart_cmd_framer

Overview:
- Sits directly downstream of the UART byte receiver.
- Consumes received bytes via rx_rdy/rx_data and returns clr_rx_rdy to the receiver.
- Assembles two consecutive bytes (high byte first) into a 16-bit command and presents it with a cmd_rdy/clr_cmd_rdy handshake to the control logic.
- Enforces an inter-byte timeout so a lost byte cannot permanently misalign framing. It also flags commands overwritten before they were consumed.

Parameters:
- CLK_RATE, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 19200, serial baud rate; must match the receiver.
- GAP_BYTES, 4, inter-byte timeout in whole byte times. 1 byte time = 10 baud periods.
- TIMEOUT_CLKS, (CLK_RATE/BAUD_RATE)*10*GAP_BYTES, timeout length in clk cycles. Default 104160. Benches may override it directly.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- rx_data  in  8  byte from receiver; valid while rx_rdy high
- rx_rdy  in  1  receiver byte-ready; may be a 1-cycle pulse or a held level
- clr_rx_rdy  out  1  1-cycle pulse acknowledging a consumed byte
- cmd  out  16  assembled command, {high_byte, low_byte}
- cmd_rdy  out  1  command valid; held until cleared
- clr_cmd_rdy  in  1  consumer acknowledge; clears cmd_rdy and overrun
- overrun  out  1  sticky: a new command completed while cmd_rdy was still high
- timeout  out  1  1-cycle pulse: high byte discarded because the low byte never arrived

Behaviour:
- Reset (asynchronous, rst_n low): all outputs 0, cmd = 16'h0000, state = WAIT_HI, timer = 0, rx_rdy_q = 0.
- Byte acceptance:
  - accept = rx_rdy & ~rx_rdy_q, where rx_rdy_q is rx_rdy registered. This is a rising-edge detect, so a held level is counted once.
  - rx_data is sampled in the accept cycle N.
  - clr_rx_rdy is registered and is high exactly in cycle N+1.
- State machine, 2 states:
  - WAIT_HI: on accept, store rx_data into hi_reg, clear timer, go to WAIT_LO. Otherwise stay.
  - WAIT_LO, on accept: cmd <= {hi_reg, rx_data}, cmd_rdy <= 1 (visible cycle N+1), go to WAIT_HI.
  - WAIT_LO, no accept: timer increments each cycle.
  - WAIT_LO, timer == TIMEOUT_CLKS-1 with no accept: pulse timeout for 1 cycle, discard hi_reg, go to WAIT_HI. cmd and cmd_rdy are unchanged.
  - WAIT_LO, accept in the same cycle as timer == TIMEOUT_CLKS-1: accept wins, the command completes, no timeout pulse.
- Timer:
  - Width is $clog2(TIMEOUT_CLKS).
  - Counts only in WAIT_LO; held at 0 in WAIT_HI.
  - Never wraps; the terminal value forces exit from WAIT_LO.
- cmd_rdy handshake:
  - Set on command completion; cleared on clr_cmd_rdy.
  - Simultaneous completion and clr_cmd_rdy: set wins, cmd updates, and overrun is NOT set.
  - cmd holds its value until the next completion; clr_cmd_rdy does not clear cmd.
- overrun:
  - Set on a completion when cmd_rdy == 1 and clr_cmd_rdy == 0 in the same cycle; cmd is overwritten with the new value.
  - Sticky until clr_cmd_rdy; clr_cmd_rdy clears both cmd_rdy and overrun.
- Bytes arriving in WAIT_HI are always treated as high bytes. No sync byte or escape handling.
- Reset asserted mid-command (in WAIT_LO): partial byte lost; the block returns to WAIT_HI with all outputs 0.
- Latency: cmd_rdy is high 1 cycle after the accept cycle of the low byte.

Decomposition:
- Shared package uart_pkg:
  - typedef enum logic {WAIT_HI, WAIT_LO} framer_state_t;
  - localparam BITS_PER_FRAME = 10, shared with the receiver and transmitter.
- No sub-module required. The timer is simple enough to stay inline; a generic timeout_cnt sub-module is optional and not needed.

Test Plan:
- Basic assembly: bytes 8'hA5 then 8'h3C as 1-cycle rx_rdy pulses, 20 cycles apart.
  -> cmd = 16'hA53C, cmd_rdy high 1 cycle after the second accept, clr_rx_rdy pulses exactly twice, overrun = 0, timeout = 0.
- Held level: rx_rdy held high for 50 cycles with rx_data = 8'h12, then low, then an 8'h34 pulse.
  -> a single acceptance for the held byte, one clr_rx_rdy pulse per byte, cmd = 16'h1234.
- Timeout resync (TIMEOUT_CLKS = 100): byte 8'hFF, no further byte for 100 cycles, then bytes 8'h01, 8'h02.
  -> timeout pulses once exactly 100 cycles after the first accept; cmd = 16'h0102, not 16'hFF01.
- Timeout tie (TIMEOUT_CLKS = 100): low byte accepted in the cycle where timer == 99.
  -> command completes, no timeout pulse.
- Overrun: two full commands (16'h1111, 16'h2222) with no clr_cmd_rdy in between.
  -> after the second, cmd = 16'h2222, cmd_rdy = 1, overrun = 1; clr_cmd_rdy then clears both.
- Handshake collision and reset:
  - clr_cmd_rdy asserted in the same cycle as a completion -> cmd_rdy stays 1, overrun stays 0.
  - rst_n asserted after the high byte, then 2 more bytes 8'hAB, 8'hCD -> all outputs 0 during reset, then cmd = 16'hABCD.
